shared_adder_scheduler: RTL and testbench

- Shares one 8-bit approximate ripple-carry adder instance (A[7:0], B[7:0], Cin -> S[7:0], Cout) among NREQ requesters in the Laplace filter datapath.
- Arbitrates requests round-robin.
- Performs each WIDTH-bit addition as WIDTH/8 sequential byte passes, chaining the carry through Cin/Cout.
- Returns the result on a single valid/ready response channel tagged with the requester ID.

---
 rtl/shared_adder_scheduler.sv | 161 ++++++++++++++++
 tb/tb_shared_adder_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_scheduler.sv
// Round-robin scheduler that time-shares one 8-bit adder across NREQ requesters, one byte lane per cycle.
// Build option: define SCHED_EXACT_ADD_EN to swap the approximate adder for an exact 8-bit add.
`ifndef SCHED_EXACT_ADD_EN
module approx_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:3] c;

  // Low three bits are an OR approximation; carry into bit 3 comes from bit 2's generate only.
  assign s[2:0] = a[2:0] | b[2:0] | {2'b00, cin};
  assign c[3]   = a[2] & b[2];

  generate
    for (genvar gi = 3; gi < 8; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[8];
endmodule
`endif

module shared_adder_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);
  localparam int LANES = WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [LW-1:0]    lane_q, lane_d;

  logic [IDW-1:0]   grant;
  logic             grant_found;
  int               grant_idx;
  logic [7:0]       add_a, add_b, add_s;
  logic             add_cout;

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      grant_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[grant_idx]) begin
        grant_found = 1'b1;
        grant       = IDW'(grant_idx);
      end
    end
  end

  assign add_a = a_q[int'(lane_q)*8 +: 8];
  assign add_b = b_q[int'(lane_q)*8 +: 8];

`ifdef SCHED_EXACT_ADD_EN
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, carry_q};
`else
  approx_add8 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    lane_d    = lane_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready = NREQ'(1) << grant;
          a_d       = req_a[int'(grant)*WIDTH +: WIDTH];
          b_d       = req_b[int'(grant)*WIDTH +: WIDTH];
          carry_d   = req_cin[grant];
          id_d      = grant;
          lane_d    = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        sum_d[int'(lane_q)*8 +: 8] = add_s;
        carry_d = add_cout;
        lane_d  = lane_q + LW'(1);
        if (lane_q == LW'(LANES - 1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = IDW'((int'(id_q) + 1) % NREQ);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      lane_q   <= lane_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler (NREQ=4, WIDTH=16); honours SCHED_EXACT_ADD_EN for expected sums.
module tb_shared_adder_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef SCHED_EXACT_ADD_EN
  localparam logic [16:0] EXP_T1 = 17'h0_1300;
  localparam logic [16:0] EXP_T2 = 17'h1_0000;
`else
  localparam logic [16:0] EXP_T1 = 17'h0_12FF;
  localparam logic [16:0] EXP_T2 = 17'h0_FFFF;
`endif

  shared_adder_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one byte lane of the adder, written arithmetically.
  function automatic logic [8:0] lane_model(input logic [7:0] a, input logic [7:0] b, input logic ci);
`ifdef SCHED_EXACT_ADD_EN
    return {1'b0, a} + {1'b0, b} + {8'h00, ci};
`else
    logic [5:0] hi;
    logic [2:0] lo;
    lo = a[2:0] | b[2:0] | {2'b00, ci};
    hi = {1'b0, a[7:3]} + {1'b0, b[7:3]} + {5'b0, (a[2] & b[2])};
    return {hi, lo};
`endif
  endfunction

  function automatic logic [16:0] add_model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [15:0] s;
    logic        c;
    logic [8:0]  r;
    c = ci;
    s = '0;
    for (int l = 0; l < 2; l++) begin
      r = lane_model(a[l*8 +: 8], b[l*8 +: 8], c);
      s[l*8 +: 8] = r[7:0];
      c = r[8];
    end
    return {c, s};
  endfunction

  logic [15:0] vals [7] = '{16'd0, 16'd1, 16'd7, 16'd8, 16'd255, 16'd256, 16'd65535};

  initial begin
    int cnt;
    int last_rise;
    logic saw_valid;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", {13'd0, rsp_id, rsp_cout, rsp_sum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single request from requester 2
    req_valid = 4'b0100; req_a[2*16 +: 16] = 16'h12FF; req_b[2*16 +: 16] = 16'h0001; req_cin[2] = 1'b0;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0; req_a[2*16 +: 16] = 16'hAAAA; req_b[2*16 +: 16] = 16'h5555;
    #1;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_add", 32'(req_ready), 32'd0);
    chk("t1_valid_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_valid_early2", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_sum", {15'd0, rsp_cout, rsp_sum}, 32'(EXP_T1));
    chk("t1_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    tick();
    chk("t1_done", 32'(busy), 32'd0);

    // Overflow from requester 3 (rr_ptr now 3)
    req_valid = 4'b1000; req_a[3*16 +: 16] = 16'hFFFF; req_b[3*16 +: 16] = 16'h0000; req_cin[3] = 1'b1;
    tick();
    req_valid = '0;
    tick(); tick();
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_sum", {15'd0, rsp_cout, rsp_sum}, 32'(EXP_T2));
    chk("t2_id", 32'(rsp_id), 32'd3);
    tick();

    // Round robin with all requesters valid
    req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = 16'(8 * (i + 1));
      req_b[i*16 +: 16] = 16'h0000;
    end
    req_valid = 4'b1111;
    last_rise = 0;
    for (int op = 0; op < 5; op++) begin
      #1;
      chk($sformatf("rr%0d_ready", op), 32'(req_ready), 32'(1) << (op % 4));
      tick();
      cnt = 0;
      while (!rsp_valid && cnt < 10) begin
        tick();
        cnt++;
      end
      chk($sformatf("rr%0d_latency", op), 32'(cnt), 32'd2);
      chk($sformatf("rr%0d_id", op), 32'(rsp_id), 32'(op % 4));
      chk($sformatf("rr%0d_sum", op), {15'd0, rsp_cout, rsp_sum}, 32'(8 * ((op % 4) + 1)));
      if (op > 0) chk($sformatf("rr%0d_spacing", op), 32'(cyc - last_rise), 32'd4);
      last_rise = cyc;
      tick();
    end
    req_valid = '0;
    tick();

    // Backpressure: rr_ptr is 1, requesters 1 and 3 valid
    rsp_ready = 1'b0;
    req_a[1*16 +: 16] = 16'h0010; req_b[1*16 +: 16] = 16'h0020;
    req_a[3*16 +: 16] = 16'h0000; req_b[3*16 +: 16] = 16'h0000;
    req_valid = 4'b1010;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h2);
    tick();
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d_rsp", k), {11'd0, rsp_valid, busy, rsp_id, rsp_cout, rsp_sum}, {11'd0, 1'b1, 1'b1, 2'd1, 17'h0_0030});
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b1011;
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    tick();

    // Reset during the second ADD cycle (rr_ptr is 2, requester 3 granted)
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_outs", {12'd0, rsp_valid, rsp_id, rsp_cout, rsp_sum}, 32'd0);
    tick();
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("rst_no_rsp", 32'(saw_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("rst_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    // Sweep on requester 0
    rsp_ready = 1'b1;
    for (int ia = 0; ia < 7; ia++) begin
      for (int ib = 0; ib < 7; ib++) begin
        for (int ci = 0; ci < 2; ci++) begin
          req_a[15:0] = vals[ia]; req_b[15:0] = vals[ib]; req_cin[0] = 1'(ci);
          req_valid = 4'b0001;
          tick();
          req_valid = '0;
          tick(); tick();
          chk($sformatf("sw_%h_%h_%0d", vals[ia], vals[ib], ci),
              {14'd0, rsp_valid, rsp_cout, rsp_sum},
              {14'd0, 1'b1, add_model(vals[ia], vals[ib], 1'(ci))});
          tick();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
